// File: rtl/spi_slave_core_pkg.sv
// rtl/spi_slave_core_pkg.sv - shared defaults, frame state type and counter sizing for the SPI slave
package spi_slave_core_pkg;

    localparam int SPI_SLAVE_DATA_W      = 8;
    localparam int SPI_SLAVE_SYNC_STAGES = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } frame_state_e;

    // The bit counter must be able to hold DATA_W itself.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/spi_slave_core_sync.sv
// rtl/spi_slave_core_sync.sv - multi-flop synchroniser with rise/fall detection
// Ports:
//   clk_i, rst_ni  system clock, asynchronous active-low reset
//   d_i            asynchronous input pin
//   q_o            synchronised level
//   rise_o/fall_o  one-cycle pulses when q_o changes against its registered copy
module spi_slave_core_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - oversampled SPI slave, all CPOL/CPHA modes, MSB/LSB first
// Ports:
//   clk_in, rst_n                 system clock (>= 4x sclk), asynchronous active-low reset
//   cpol, cpha, lsb               mode, captured at the start of each frame
//   tx_data/tx_valid/tx_ready     transmit shadow buffer write handshake
//   rx_data/rx_valid              last received character, one-cycle update pulse
//   tx_underrun                   pulse: a character started with the shadow empty
//   busy                          frame in progress
//   sclk, ss_n, mosi              asynchronous SPI pins from the master
//   miso, miso_oe                 slave data out and its output enable
module spi_slave_core
    import spi_slave_core_pkg::*;
#(
    parameter int DATA_W      = SPI_SLAVE_DATA_W,
    parameter int SYNC_STAGES = SPI_SLAVE_SYNC_STAGES
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe
);

    localparam int              CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    frame_state_e      state_q, state_d;
    logic              cpol_q, cpha_q, lsb_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d, shadow_q, shadow_d;
    logic              shadow_full_q, shadow_full_d;
    logic              rx_valid_q, rx_valid_d, underrun_q, underrun_d;
    logic              miso_q, miso_d;

    logic              frame_start, in_frame, leading, trailing;
    logic              sample_ev, shift_ev, load_ev, tx_write, eff_cpha, eff_lsb;
    logic [DATA_W-1:0] rx_shift, load_val;

    spi_slave_core_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk_in), .rst_ni(rst_n), .d_i(sclk),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_slave_core_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk_i(clk_in), .rst_ni(rst_n), .d_i(ss_n),
        .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    // mosi needs the same latency as sclk so it is sampled as seen at the sclk pin edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) mosi_sync_q <= '0;
        else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end

    assign frame_start = (state_q == ST_IDLE) && ss_fall && !ss_s;
    assign in_frame    = (state_q == ST_FRAME) && !ss_rise;
    assign leading     = cpol_q ? sclk_fall : sclk_rise;
    assign trailing    = cpol_q ? sclk_rise : sclk_fall;
    assign sample_ev   = in_frame && (cpha_q ? trailing : leading);
    // With cpha=0 the first bit is already on miso at char start, so the trailing edge
    // that closes a character (counter back at 0) must not shift again.
    assign shift_ev    = in_frame && (cpha_q ? leading : (trailing && cnt_q != '0));
    assign load_ev     = frame_start || (sample_ev && cnt_q == LAST_CNT);
    assign tx_write    = tx_valid && !shadow_full_q;
    // The mode registers are written in the frame_start cycle, so use the pins then.
    assign eff_cpha    = frame_start ? cpha : cpha_q;
    assign eff_lsb     = frame_start ? lsb  : lsb_q;
    assign rx_shift    = lsb_q ? {mosi_sync_q[SYNC_STAGES-1], rx_sr_q[DATA_W-1:1]}
                               : {rx_sr_q[DATA_W-2:0], mosi_sync_q[SYNC_STAGES-1]};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rx_sr_d       = rx_sr_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        underrun_d    = 1'b0;
        tx_sr_d       = tx_sr_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        miso_d        = miso_q;
        load_val      = shadow_q;

        if (tx_write) begin
            shadow_d      = tx_data;
            shadow_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_FRAME;
                    cnt_d   = '0;
                end
            end
            ST_FRAME: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (sample_ev) begin
            rx_sr_d = rx_shift;
            if (cnt_q == LAST_CNT) begin
                cnt_d      = '0;
                rx_data_d  = rx_shift;
                rx_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (shift_ev) begin
            miso_d  = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
            tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
        end

        if (load_ev) begin
            // A write landing in the load cycle bypasses the shadow, leaving it empty.
            shadow_full_d = 1'b0;
            if (shadow_full_q)  load_val = shadow_q;
            else if (tx_write)  load_val = tx_data;
            else begin
                load_val   = '0;
                underrun_d = 1'b1;
            end
            if (eff_cpha) begin
                tx_sr_d = load_val;
            end else begin
                miso_d  = eff_lsb ? load_val[0] : load_val[DATA_W-1];
                tx_sr_d = eff_lsb ? (load_val >> 1) : (load_val << 1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            lsb_q         <= 1'b0;
            cnt_q         <= '0;
            rx_sr_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            underrun_q    <= 1'b0;
            tx_sr_q       <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            if (frame_start) begin
                cpol_q <= cpol;
                cpha_q <= cpha;
                lsb_q  <= lsb;
            end
            cnt_q         <= cnt_d;
            rx_sr_q       <= rx_sr_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            underrun_q    <= underrun_d;
            tx_sr_q       <= tx_sr_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            miso_q        <= miso_d;
        end
    end

    assign tx_ready    = !shadow_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign busy        = (state_q == ST_FRAME);
    assign miso_oe     = busy;
    assign miso        = miso_q;

endmodule
